// File: rtl/ex_operand_stage_if.sv
// Bundles the decode-side issue port, MEM/WB forwarding buses, flush and the ALU-side output
// of the execute operand stage into one interface.
interface ex_operand_stage_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [RA_W-1:0]  in_rs_addr;
  logic [RA_W-1:0]  in_rt_addr;
  logic [WIDTH-1:0] in_rs_data;
  logic [WIDTH-1:0] in_rt_data;
  logic [WIDTH-1:0] in_imm;
  logic             in_alu_src;
  logic [2:0]       in_alu_op;
  logic [RA_W-1:0]  in_rd_addr;
  logic             in_reg_write;

  logic             mem_reg_write;
  logic [RA_W-1:0]  mem_rd_addr;
  logic [WIDTH-1:0] mem_result;
  logic             wb_reg_write;
  logic [RA_W-1:0]  wb_rd_addr;
  logic [WIDTH-1:0] wb_result;

  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [2:0]       op;
  logic [RA_W-1:0]  out_rd_addr;
  logic             out_reg_write;

  modport master (
    output in_valid, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data, in_imm,
           in_alu_src, in_alu_op, in_rd_addr, in_reg_write,
           mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
           flush, out_ready,
    input  in_ready, out_valid, num1, num2, op, out_rd_addr, out_reg_write
  );

  modport slave (
    input  in_valid, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data, in_imm,
           in_alu_src, in_alu_op, in_rd_addr, in_reg_write,
           mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
           flush, out_ready,
    output in_ready, out_valid, num1, num2, op, out_rd_addr, out_reg_write
  );
endinterface

// File: rtl/ex_operand_stage.sv
// One-entry ALU operand register with MEM/WB forwarding; 1-cycle capture-to-out_valid latency.
// in_ready = !out_valid | out_ready; a stalled entry keeps refreshing its operands from MEM/WB.
module ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input logic clk,
  input logic rst_n,
  ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] n1;
    logic [WIDTH-1:0] n2;
    logic [2:0]       op;
    logic [RA_W-1:0]  rd;
    logic             rw;
    logic [RA_W-1:0]  rs_tag;
    logic [RA_W-1:0]  rt_tag;
    logic             src;
  } entry_t;

  entry_t q, d;

  logic             mem_we, wb_we;
  logic [RA_W-1:0]  mem_rd, wb_rd;
  logic [WIDTH-1:0] mem_res, wb_res;
  logic             ready, capture;
  logic [WIDTH-1:0] rt_fwd;

  assign mem_we  = bus.mem_reg_write;
  assign mem_rd  = bus.mem_rd_addr;
  assign mem_res = bus.mem_result;
  assign wb_we   = bus.wb_reg_write;
  assign wb_rd   = bus.wb_rd_addr;
  assign wb_res  = bus.wb_result;

  // MEM is the younger producer, so it wins over WB; r0 is always zero.
  function automatic logic [WIDTH-1:0] fwd(
    input logic [RA_W-1:0]  a,
    input logic [WIDTH-1:0] dflt,
    input logic             mw,
    input logic [RA_W-1:0]  mrd,
    input logic [WIDTH-1:0] mres,
    input logic             ww,
    input logic [RA_W-1:0]  wrd,
    input logic [WIDTH-1:0] wres
  );
    if (a == '0)                  return '0;
    else if (mw && (mrd == a))    return mres;
    else if (ww && (wrd == a))    return wres;
    else                          return dflt;
  endfunction

  assign ready   = !q.vld || bus.out_ready;
  assign capture = bus.in_valid && ready && !bus.flush;
  assign rt_fwd  = fwd(bus.in_rt_addr, bus.in_rt_data, mem_we, mem_rd, mem_res, wb_we, wb_rd, wb_res);

  always_comb begin
    d = q;
    if (bus.flush) begin
      d.vld = 1'b0;
    end else if (capture) begin
      d.vld    = 1'b1;
      d.n1     = fwd(bus.in_rs_addr, bus.in_rs_data, mem_we, mem_rd, mem_res, wb_we, wb_rd, wb_res);
      d.n2     = bus.in_alu_src ? bus.in_imm : rt_fwd;
      d.op     = bus.in_alu_op;
      d.rd     = bus.in_rd_addr;
      d.rw     = bus.in_reg_write;
      d.rs_tag = bus.in_rs_addr;
      d.rt_tag = bus.in_rt_addr;
      d.src    = bus.in_alu_src;
    end else if (q.vld && bus.out_ready) begin
      d.vld = 1'b0;
    end else if (q.vld) begin
      // Stalled: pick up producers that retire while we wait.
      d.n1 = fwd(q.rs_tag, q.n1, mem_we, mem_rd, mem_res, wb_we, wb_rd, wb_res);
      if (!q.src) begin
        d.n2 = fwd(q.rt_tag, q.n2, mem_we, mem_rd, mem_res, wb_we, wb_rd, wb_res);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign bus.in_ready      = ready;
  assign bus.out_valid     = q.vld;
  assign bus.num1          = q.n1;
  assign bus.num2          = q.n2;
  assign bus.op            = q.op;
  assign bus.out_rd_addr   = q.rd;
  assign bus.out_reg_write = q.rw && q.vld;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expected entries queued at issue, compared on dequeue.
module tb_ex_operand_stage;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  typedef struct {
    logic [31:0] n1;
    logic [31:0] n2;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sbq[$];

  ex_operand_stage_if #(.WIDTH(32), .RA_W(5)) bus ();

  ex_operand_stage #(.WIDTH(32), .RA_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] n1, input logic [31:0] n2, input logic [2:0] op,
                      input logic [4:0] rd, input logic rw);
    exp_t e;
    e.n1 = n1; e.n2 = n2; e.op = op; e.rd = rd; e.rw = rw;
    sbq.push_back(e);
  endtask

  // Samples the output port before the edge, then advances one clock.
  task automatic cycle();
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_entry", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("sb_num1", bus.num1, e.n1);
        chk("sb_num2", bus.num2, e.n2);
        chk("sb_op", 32'(bus.op), 32'(e.op));
        chk("sb_rd", 32'(bus.out_rd_addr), 32'(e.rd));
        chk("sb_rw", 32'(bus.out_reg_write), 32'(e.rw));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [31:0] imm, input logic src,
                       input logic [2:0] op, input logic [4:0] rd, input logic rw);
    bus.in_valid     = 1'b1;
    bus.in_rs_addr   = rs;
    bus.in_rt_addr   = rt;
    bus.in_rs_data   = rsd;
    bus.in_rt_data   = rtd;
    bus.in_imm       = imm;
    bus.in_alu_src   = src;
    bus.in_alu_op    = op;
    bus.in_rd_addr   = rd;
    bus.in_reg_write = rw;
  endtask

  task automatic set_mem(input logic we, input logic [4:0] rd, input logic [31:0] res);
    bus.mem_reg_write = we; bus.mem_rd_addr = rd; bus.mem_result = res;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] res);
    bus.wb_reg_write = we; bus.wb_rd_addr = rd; bus.wb_result = res;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    set_mem(0, 0, 0);
    set_wb(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_num1", bus.num1, 32'd0);
    chk("rst_num2", bus.num2, 32'd0);
    chk("rst_op", 32'(bus.op), 32'd0);
    chk("rst_rd", 32'(bus.out_rd_addr), 32'd0);
    chk("rst_reg_write", 32'(bus.out_reg_write), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain issue
    bus.out_ready = 1'b1;
    drive(3, 4, 32'h10, 32'h20, 32'h0, 0, 3'b010, 5'd9, 1);
    push(32'h10, 32'h20, 3'b010, 5'd9, 1);
    cycle();
    bus.in_valid = 1'b0;
    chk("issue_out_valid", 32'(bus.out_valid), 32'd1);
    cycle();
    chk("issue_drained", 32'(bus.out_valid), 32'd0);

    // Forward priority on rs, then WB-only, then zero register, then rt from WB
    drive(5, 1, 32'h1, 32'h3, 32'h0, 0, 3'b001, 5'd2, 1);
    set_mem(1, 5, 32'hAAAA);
    set_wb(1, 5, 32'hBBBB);
    push(32'hAAAA, 32'h3, 3'b001, 5'd2, 1);
    cycle();
    set_mem(0, 5, 32'hAAAA);
    push(32'hBBBB, 32'h3, 3'b001, 5'd2, 1);
    cycle();
    drive(0, 0, 32'h5, 32'h6, 32'h0, 0, 3'b100, 5'd3, 0);
    set_mem(1, 0, 32'hFFFF);
    set_wb(1, 0, 32'hEEEE);
    push(32'h0, 32'h0, 3'b100, 5'd3, 0);
    cycle();
    drive(8, 9, 32'h11, 32'h22, 32'h0, 0, 3'b111, 5'd4, 1);
    set_mem(1, 8, 32'hCAFE_0008);
    set_wb(1, 9, 32'hBEEF_0009);
    push(32'hCAFE_0008, 32'hBEEF_0009, 3'b111, 5'd4, 1);
    cycle();
    bus.in_valid = 1'b0;
    set_mem(0, 0, 0);
    set_wb(0, 0, 0);
    cycle();
    chk("fwd_drained", 32'(bus.out_valid), 32'd0);

    // Stall refresh, alu_src=0: both operands pick up late producers
    bus.out_ready = 1'b0;
    drive(6, 7, 32'h66, 32'h55, 32'h0, 0, 3'b011, 5'd10, 1);
    cycle();
    drive(1, 2, 32'hDEAD, 32'hDEAD, 32'h0, 0, 3'b110, 5'd20, 0);
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_num2_pre", bus.num2, 32'h55);
    set_wb(1, 7, 32'h1234);
    set_mem(1, 6, 32'h77);
    cycle();
    set_mem(0, 0, 0);
    set_wb(0, 0, 0);
    chk("stall_num1_refresh", bus.num1, 32'h77);
    chk("stall_num2_refresh", bus.num2, 32'h1234);
    chk("stall_op_hold", 32'(bus.op), 32'd3);
    chk("stall_rd_hold", 32'(bus.out_rd_addr), 32'd10);
    cycle();
    chk("stall_num2_keep", bus.num2, 32'h1234);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    push(32'h77, 32'h1234, 3'b011, 5'd10, 1);
    cycle();

    // Stall refresh, alu_src=1: immediate must not be overwritten
    bus.out_ready = 1'b0;
    drive(6, 7, 32'h66, 32'h55, 32'h8, 1, 3'b101, 5'd11, 0);
    cycle();
    bus.in_valid = 1'b0;
    set_wb(1, 7, 32'h1234);
    cycle();
    set_wb(0, 0, 0);
    chk("stall_imm_keep", bus.num2, 32'h8);
    chk("stall_rw_off", 32'(bus.out_reg_write), 32'd0);
    bus.out_ready = 1'b1;
    push(32'h66, 32'h8, 3'b101, 5'd11, 0);
    cycle();
    chk("stall_drained", 32'(bus.out_valid), 32'd0);

    // Back-to-back with no bubble
    for (int i = 0; i < 3; i++) begin
      drive(5'(i + 1), 5'(i + 4), 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h0, 0, 3'(i), 5'(i + 12), 1);
      push(32'h100 + 32'(i), 32'h200 + 32'(i), 3'(i), 5'(i + 12), 1);
      cycle();
      chk("b2b_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    cycle();
    chk("b2b_drained", 32'(bus.out_valid), 32'd0);

    // Flush during the second capture: that entry must never appear
    drive(1, 2, 32'hA1, 32'hA2, 32'h0, 0, 3'b001, 5'd21, 1);
    push(32'hA1, 32'hA2, 3'b001, 5'd21, 1);
    cycle();
    drive(1, 2, 32'hB1, 32'hB2, 32'h0, 0, 3'b010, 5'd22, 1);
    bus.flush = 1'b1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    cycle();
    bus.flush = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    drive(1, 2, 32'hC1, 32'hC2, 32'h0, 0, 3'b011, 5'd23, 1);
    push(32'hC1, 32'hC2, 3'b011, 5'd23, 1);
    cycle();
    bus.in_valid = 1'b0;
    cycle();

    // Asynchronous reset while an entry is held
    bus.out_ready = 1'b0;
    drive(3, 4, 32'h31, 32'h41, 32'h0, 0, 3'b110, 5'd5, 1);
    cycle();
    bus.in_valid = 1'b0;
    chk("arst_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_num1", bus.num1, 32'd0);
    chk("arst_num2", bus.num2, 32'd0);
    chk("arst_op", 32'(bus.op), 32'd0);
    chk("arst_reg_write", 32'(bus.out_reg_write), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drive(9, 10, 32'h91, 32'hA1, 32'h0, 0, 3'b111, 5'd7, 1);
    push(32'h91, 32'hA1, 3'b111, 5'd7, 1);
    cycle();
    bus.in_valid = 1'b0;
    cycle();

    chk("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
